// File: rtl/cacheline_adaptor.sv
// Splits 256-bit cache line reads/writes into four 64-bit memory bursts,
// least-significant beat first.
module cacheline_adaptor #(
  parameter int unsigned s_line  = 256,
  parameter int unsigned s_burst = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         pmem_address,
  input  logic                pmem_read,
  input  logic                pmem_write,
  input  logic [s_line-1:0]   pmem_wdata,
  output logic [s_line-1:0]   pmem_rdata,
  output logic                pmem_resp,
  output logic [31:0]         mem_address,
  output logic                mem_read,
  output logic                mem_write,
  output logic [s_burst-1:0]  mem_wdata,
  input  logic [s_burst-1:0]  mem_rdata,
  input  logic                mem_resp
);

  localparam int unsigned num_beats = s_line / s_burst;
  localparam int unsigned cnt_w     = $clog2(num_beats);
  localparam int unsigned off_w     = $clog2(s_line / 8);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t                               state;
  logic [cnt_w-1:0]                     cnt;
  logic [num_beats-1:0][s_burst-1:0]    wr_line;
  logic [num_beats-1:0][s_burst-1:0]    rd_line;
  logic [num_beats-1:0][s_burst-1:0]    rd_next;
  logic                                 last_beat;
  logic                                 addr_unused;

  // Line offset bits are dropped; the memory always sees line-aligned addresses.
  assign addr_unused = ^pmem_address[off_w-1:0];
  assign last_beat   = (cnt == cnt_w'(num_beats - 1));

  // Assembly buffer with the current beat merged in, so the final beat lands
  // in pmem_rdata on the same edge it is acknowledged.
  always_comb begin
    rd_next      = rd_line;
    rd_next[cnt] = mem_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      wr_line     <= '0;
      rd_line     <= '0;
      pmem_rdata  <= '0;
      pmem_resp   <= 1'b0;
      mem_address <= '0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_wdata   <= '0;
    end else begin
      pmem_resp <= 1'b0;
      case (state)
        IDLE: begin
          if (pmem_write) begin
            state       <= WRITE;
            cnt         <= '0;
            wr_line     <= pmem_wdata;
            mem_wdata   <= pmem_wdata[s_burst-1:0];
            mem_address <= {pmem_address[31:off_w], off_w'(0)};
            mem_write   <= 1'b1;
          end else if (pmem_read) begin
            state       <= READ;
            cnt         <= '0;
            mem_address <= {pmem_address[31:off_w], off_w'(0)};
            mem_read    <= 1'b1;
          end
        end
        READ: begin
          if (mem_resp) begin
            rd_line[cnt] <= mem_rdata;
            cnt          <= cnt_w'(cnt + 1'b1);
            if (last_beat) begin
              state      <= DONE;
              mem_read   <= 1'b0;
              pmem_resp  <= 1'b1;
              pmem_rdata <= rd_next;
            end
          end
        end
        WRITE: begin
          if (mem_resp) begin
            cnt <= cnt_w'(cnt + 1'b1);
            if (last_beat) begin
              state     <= DONE;
              mem_write <= 1'b0;
              pmem_resp <= 1'b1;
            end else begin
              mem_wdata <= wr_line[cnt_w'(cnt + 1'b1)];
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed bench for cacheline_adaptor: reads, waited writes, arbitration,
// back-to-back requests, stray acks and mid-transaction reset.
module tb_cacheline_adaptor;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  pmem_address;
  logic         pmem_read;
  logic         pmem_write;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;
  logic [31:0]  mem_address;
  logic         mem_read;
  logic         mem_write;
  logic [63:0]  mem_wdata;
  logic [63:0]  mem_rdata;
  logic         mem_resp;

  int checks   = 0;
  int failures = 0;

  cacheline_adaptor dut (
    .clk          (clk),
    .rst          (rst),
    .pmem_address (pmem_address),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp),
    .mem_address  (mem_address),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_resp     (mem_resp)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One acknowledged memory beat carrying d.
  task automatic beat(input logic [63:0] d);
    mem_resp  = 1'b1;
    mem_rdata = d;
    tick();
    mem_resp  = 1'b0;
  endtask

  logic [63:0]  ra [4] = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                           64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
  logic [63:0]  wd [4] = '{64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                           64'hA5A5_5A5A_0F0F_F0F0, 64'hDEAD_BEEF_CAFE_F00D};
  logic [63:0]  ba [4] = '{64'hAAAA_0000_0000_0001, 64'hAAAA_0000_0000_0002,
                           64'hAAAA_0000_0000_0003, 64'hAAAA_0000_0000_0004};
  logic [63:0]  bb [4] = '{64'hBBBB_0000_0000_0010, 64'hBBBB_0000_0000_0020,
                           64'hBBBB_0000_0000_0030, 64'hBBBB_0000_0000_0040};
  logic [63:0]  rc [4] = '{64'hC0C0_C0C0_0000_0001, 64'hC0C0_C0C0_0000_0002,
                           64'hC0C0_C0C0_0000_0003, 64'hC0C0_C0C0_0000_0004};
  logic [255:0] exp1, exp_a, exp_b, exp_c, both_line;
  int           acks;

  initial begin
    exp1      = {ra[3], ra[2], ra[1], ra[0]};
    exp_a     = {ba[3], ba[2], ba[1], ba[0]};
    exp_b     = {bb[3], bb[2], bb[1], bb[0]};
    exp_c     = {rc[3], rc[2], rc[1], rc[0]};
    both_line = {64'h4, 64'h3, 64'h2, 64'h5555_6666_7777_8888};

    rst = 1'b1; pmem_address = '0; pmem_read = 1'b0; pmem_write = 1'b0;
    pmem_wdata = '0; mem_rdata = '0; mem_resp = 1'b0;
    tick(); tick();
    chk("rst_pmem_rdata", pmem_rdata, '0);
    chk("rst_pmem_resp", pmem_resp, 0);
    chk("rst_mem_address", mem_address, 0);
    chk("rst_mem_read", mem_read, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    rst = 1'b0;
    tick();

    // Read with no wait states
    pmem_address = 32'h0000_1234; pmem_read = 1'b1;
    tick();
    chk("t1_mem_read_on", mem_read, 1);
    chk("t1_mem_address", mem_address, 32'h0000_1220);
    chk("t1_mem_write_off", mem_write, 0);
    for (int i = 0; i < 4; i++) begin
      chk("t1_no_early_resp", pmem_resp, 0);
      chk("t1_mem_read_held", mem_read, 1);
      beat(ra[i]);
    end
    chk("t1_pmem_resp", pmem_resp, 1);
    chk("t1_mem_read_drop", mem_read, 0);
    chk("t1_pmem_rdata", pmem_rdata, exp1);
    pmem_read = 1'b0;
    tick();
    chk("t1_resp_one_cycle", pmem_resp, 0);
    chk("t1_idle_mem_read", mem_read, 0);

    // Stray acks while idle
    mem_resp = 1'b1; mem_rdata = '1;
    tick(); tick();
    mem_resp = 1'b0;
    chk("stray_mem_read", mem_read, 0);
    chk("stray_mem_write", mem_write, 0);
    chk("stray_pmem_resp", pmem_resp, 0);
    chk("stray_pmem_rdata", pmem_rdata, exp1);
    tick();

    // Write with acks in cycles 3, 4, 7, 9 and wdata scrambled after acceptance
    pmem_wdata = {wd[3], wd[2], wd[1], wd[0]};
    pmem_address = 32'hABCD_EF7F; pmem_write = 1'b1;
    tick();
    pmem_wdata = ~pmem_wdata;
    chk("t2_mem_address", mem_address, 32'hABCD_EF60);
    chk("t2_mem_read_off", mem_read, 0);
    acks = 0;
    for (int c = 1; c <= 9; c++) begin
      chk("t2_mem_write_held", mem_write, 1);
      chk("t2_mem_wdata", mem_wdata, wd[acks]);
      chk("t2_no_early_resp", pmem_resp, 0);
      mem_resp = (c == 3 || c == 4 || c == 7 || c == 9);
      tick();
      if (mem_resp) acks++;
      mem_resp = 1'b0;
    end
    chk("t2_pmem_resp", pmem_resp, 1);
    chk("t2_mem_write_drop", mem_write, 0);
    pmem_write = 1'b0;
    tick();
    chk("t2_resp_one_cycle", pmem_resp, 0);
    chk("t2_idle_mem_write", mem_write, 0);

    // Simultaneous read and write: write wins
    pmem_wdata = both_line; pmem_address = 32'h0000_0040;
    pmem_read = 1'b1; pmem_write = 1'b1;
    tick();
    chk("t3_mem_write_on", mem_write, 1);
    chk("t3_mem_wdata0", mem_wdata, 64'h5555_6666_7777_8888);
    for (int i = 0; i < 4; i++) begin
      chk("t3_mem_read_never", mem_read, 0);
      beat(64'hFFFF_FFFF_FFFF_FFFF);
    end
    chk("t3_pmem_resp", pmem_resp, 1);
    chk("t3_mem_write_drop", mem_write, 0);
    chk("t3_mem_read_done", mem_read, 0);
    chk("t3_rdata_stable", pmem_rdata, exp1);
    pmem_read = 1'b0; pmem_write = 1'b0;
    tick();

    // Back-to-back reads
    pmem_address = 32'h0000_0100; pmem_read = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) beat(ba[i]);
    chk("t4_resp_a", pmem_resp, 1);
    chk("t4_done_mem_read", mem_read, 0);
    chk("t4_rdata_a", pmem_rdata, exp_a);
    pmem_address = 32'h2000_0045;
    tick();
    chk("t4_idle_mem_read", mem_read, 0);
    chk("t4_idle_resp", pmem_resp, 0);
    tick();
    chk("t4_second_accept", mem_read, 1);
    chk("t4_second_addr", mem_address, 32'h2000_0040);
    chk("t4_rdata_hold", pmem_rdata, exp_a);
    beat(bb[0]);
    tick();
    beat(bb[1]);
    beat(bb[2]);
    chk("t4_rdata_hold_mid", pmem_rdata, exp_a);
    chk("t4_no_early_resp", pmem_resp, 0);
    beat(bb[3]);
    chk("t4_resp_b", pmem_resp, 1);
    chk("t4_rdata_b", pmem_rdata, exp_b);
    pmem_read = 1'b0;
    tick();

    // Reset after two beats of a read, then a normal read
    pmem_address = 32'h3000_0000; pmem_read = 1'b1;
    tick();
    beat(64'hDEAD_0000_0000_0000);
    beat(64'hDEAD_0000_0000_0001);
    chk("t5_mid_mem_read", mem_read, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0; pmem_read = 1'b0;
    chk("t5_rst_mem_read", mem_read, 0);
    chk("t5_rst_rdata", pmem_rdata, '0);
    chk("t5_rst_resp", pmem_resp, 0);
    chk("t5_rst_addr", mem_address, 0);
    tick();
    chk("t5_no_resp_after", pmem_resp, 0);
    chk("t5_idle_mem_read", mem_read, 0);
    pmem_address = 32'h0000_0080; pmem_read = 1'b1;
    tick();
    chk("t5_new_mem_read", mem_read, 1);
    chk("t5_new_addr", mem_address, 32'h0000_0080);
    for (int i = 0; i < 4; i++) beat(rc[i]);
    chk("t5_resp", pmem_resp, 1);
    chk("t5_rdata", pmem_rdata, exp_c);
    pmem_read = 1'b0;
    tick();
    chk("t5_resp_one_cycle", pmem_resp, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
